// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core (master) and the iterative RV32M
// multiply/divide unit (slave).
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operandA;
  logic [XLEN-1:0] operandB;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, operandA, operandB, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, operandA, operandB, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply (shift-add) / divide (restoring), one bit per cycle.
// Define MULDIV_EARLY_EN to finish divide-by-zero and signed overflow right after start.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);
  localparam int unsigned CntW = $clog2(XLEN) + 1;
`ifdef MULDIV_EARLY_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic              dz_q, dz_d, ovf_q, ovf_d, early_q, early_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, opa_q, opa_d, res_q, res_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic              in_sa, in_sb, in_dz, in_ovf;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_nxt, prod_fix;
  logic [XLEN-1:0]   quo_nxt, quo_fix, rem_nxt, rem_fix;

  assign in_sa  = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                  (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign in_sb  = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                  (bus.funct3 == 3'b110);
  assign in_dz  = bus.funct3[2] && (bus.operandB == '0);
  assign in_ovf = bus.funct3[2] && !bus.funct3[0] &&
                  (bus.operandA == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.operandB);

  // Multiplier lives in the low half of acc and is consumed from bit 0.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign prod_nxt = {mul_sum, acc_q[XLEN-1:1]};
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod_nxt : prod_nxt;

  // Shifted partial remainder is always < 2*divisor, so the top bit of the
  // difference is a valid borrow.
  assign div_shift = {rem_q, a_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign quo_nxt   = {a_q[XLEN-2:0], ~div_diff[XLEN]};
  assign rem_nxt   = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];

  always_comb begin
    quo_fix = (neg_a_q ^ neg_b_q) ? -quo_nxt : quo_nxt;
    rem_fix = neg_a_q ? -rem_nxt : rem_nxt;
    if (dz_q) begin
      quo_fix = '1;
      rem_fix = opa_q;
    end else if (ovf_q) begin
      quo_fix = {1'b1, {(XLEN-1){1'b0}}};
      rem_fix = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    early_d = early_q;
    a_d     = a_q;
    b_d     = b_q;
    opa_d   = opa_q;
    res_d   = res_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StCalc;
          cnt_d   = '0;
          op_d    = bus.funct3;
          rd_d    = bus.rd_in;
          neg_a_d = in_sa && bus.operandA[XLEN-1];
          neg_b_d = in_sb && bus.operandB[XLEN-1];
          dz_d    = in_dz;
          ovf_d   = in_ovf;
          early_d = EarlyEn && (in_dz || in_ovf);
          a_d     = (in_sa && bus.operandA[XLEN-1]) ? -bus.operandA : bus.operandA;
          b_d     = (in_sb && bus.operandB[XLEN-1]) ? -bus.operandB : bus.operandB;
          opa_d   = bus.operandA;
          rem_d   = '0;
          acc_d   = {{XLEN{1'b0}}, b_d};
        end
      end
      StCalc: begin
        cnt_d = cnt_q + CntW'(1);
        if (op_q[2]) begin
          a_d   = quo_nxt;
          rem_d = rem_nxt;
        end else begin
          acc_d = prod_nxt;
        end
        if ((cnt_q == CntW'(XLEN - 1)) || early_q) begin
          state_d = StDone;
          case (op_q)
            3'b000:                 res_d = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_d = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res_d = quo_fix;
            default:                res_d = rem_fix;
          endcase
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      early_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      opa_q   <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      early_q <= early_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opa_q   <= opa_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = (state_q == StDone);
  assign bus.result = res_q;
  assign bus.rd_out = rd_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, rd capture, latency, start
// while busy, and asynchronous reset mid-operation.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

`ifdef MULDIV_EARLY_EN
  localparam int SpecLat = 1;
`else
  localparam int SpecLat = 32;
`endif
  localparam int NormLat = 32;

  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // k counts rising edges after the start edge; outputs sampled on falling edges.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat, input bit poke);
    int k;
    bit seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.funct3   = f;
    bus.operandA = a;
    bus.operandB = b;
    bus.rd_in    = rd;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.funct3   = ~f;
    bus.operandA = ~a;
    bus.operandB = b ^ 32'h5;
    bus.rd_in    = ~rd;
    k    = 0;
    seen = 1'b0;
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    while (!seen && k < 40) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        k++;
        bus.start = poke && (k == 5);
      end
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 32'(k), 32'(exp_lat));
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " rd_out"}, 32'(bus.rd_out), 32'(rd));
    @(negedge clk);
    check({tag, " done low"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int ndone;
    bus.start    = 1'b0;
    bus.funct3   = 3'b000;
    bus.operandA = '0;
    bus.operandB = '0;
    bus.rd_in    = '0;
    rst_n        = 1'b1;
    #2 rst_n     = 1'b0;
    #1;
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst result", bus.result, 32'd0);
    check("rst rd_out", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul",     3'b000, 32'd7,        32'd6,        5'd5,  32'd42,       NormLat, 1'b0);
    run_op("mul neg", 3'b000, 32'hFFFFFFFD, 32'd5,        5'd1,  32'hFFFFFFF1, NormLat, 1'b0);
    run_op("mulh",    3'b001, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, NormLat, 1'b0);
    run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, NormLat, 1'b0);
    run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, NormLat, 1'b0);
    run_op("div",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, NormLat, 1'b0);
    run_op("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, NormLat, 1'b0);
    run_op("divu",    3'b101, 32'd100,      32'd7,        5'd8,  32'd14,       NormLat, 1'b0);
    run_op("remu",    3'b111, 32'd100,      32'd7,        5'd9,  32'd2,        NormLat, 1'b0);
    run_op("divu/0",  3'b101, 32'd100,      32'd0,        5'd10, 32'hFFFFFFFF, SpecLat, 1'b0);
    run_op("remu/0",  3'b111, 32'd100,      32'd0,        5'd11, 32'd100,      SpecLat, 1'b0);
    run_op("div/0",   3'b100, 32'hFFFFFFF9, 32'd0,        5'd12, 32'hFFFFFFFF, SpecLat, 1'b0);
    run_op("rem/0",   3'b110, 32'hFFFFFFF9, 32'd0,        5'd13, 32'hFFFFFFF9, SpecLat, 1'b0);
    run_op("div ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, SpecLat, 1'b0);
    run_op("rem ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        SpecLat, 1'b0);
    run_op("poke",    3'b000, 32'd123,      32'd3,        5'd9,  32'd369,      NormLat, 1'b1);

    // Reset in the middle of a divide.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.funct3   = 3'b100;
    bus.operandA = 32'd1000;
    bus.operandB = 32'd3;
    bus.rd_in    = 5'd17;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst busy", 32'(bus.busy), 32'd0);
    check("mid rst done", 32'(bus.done), 32'd0);
    check("mid rst result", bus.result, 32'd0);
    check("mid rst rd_out", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("no done after rst", 32'(ndone), 32'd0);
    run_op("post rst", 3'b101, 32'd1000, 32'd3, 5'd17, 32'd333, NormLat, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit between the register file read ports and the write-back path. It takes the two operands read from `output_rs1` and `output_rs2`, plus the destination register index, and runs a shift-add or restoring-division loop. It then presents the result with a one-cycle `done` pulse that drives register-file write enable and data. The core holds the issuing instruction while `busy` is high.

Parameters:
- XLEN, 32, operand/result width; counter width = $clog2(XLEN)+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operandA  input  XLEN  rs1 value (multiplicand/dividend).
- operandB  input  XLEN  rs2 value (multiplier/divisor).
- rd_in  input  5  destination register index.
- busy  output  1  high in CALC (and DONE); core stalls the PC.
- done  output  1  one-cycle pulse; result and rd_out valid.
- result  output  XLEN  registered result, held until the next completion.
- rd_out  output  5  destination index captured at start.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0; done=0; result=0; rd_out=0; internal counter, accumulators and sign flags cleared.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at edge E0:
  - capture funct3 and rd_in;
  - record operand signs per op (MULH/DIV/REM: both signed; MULHSU: A only; others unsigned);
  - load magnitudes; count=0; go to CALC.
- start=1 outside IDLE is ignored; no queuing.
- CALC, multiply: 2*XLEN-bit shift-add on magnitudes, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle; remainder register XLEN+1 bits.
- CALC runs exactly XLEN cycles (edges E1..E32). At E32, sign-correct and load `result`, go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. With XLEN=32, done is high in the cycle after E32, i.e. 33 cycles after E0.
- Result selection:
  - MUL: low XLEN of the signed product.
  - MULH/MULHSU/MULHU: high XLEN.
  - Product negated when the signs of the signed-interpreted operands differ.
  - Quotient negated when dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero (operandB=0):
  - DIV/DIVU result = all-ones;
  - REM/REMU result = operandA;
  - same latency as normal.
- Signed overflow (DIV, A=0x80000000, B=0xFFFFFFFF): DIV result=0x80000000; REM result=0.
- `start` may be asserted in the cycle right after DONE; back-to-back operations are therefore 34 cycles apart.
- Operands and rd_in are sampled only at E0. Later changes have no effect.

Optional Feature:
- Macro: MULDIV_EARLY_EN.
- Defined: a start with divide by zero or signed overflow skips CALC. The special result loads at E0+1 and done is high in the following cycle (2 cycles after E0). Multiplies and normal divides are unchanged.
- Undefined: all ops take the full XLEN-cycle latency.

Test Plan:
- MUL A=7, B=6, rd_in=5 -> busy rises after E0; done exactly 33 cycles later; result=42, rd_out=5; done low the next cycle.
- MULH A=B=0x80000000 -> result=0x40000000. MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD. REM same -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU -> 2.
- DIVU A=100, B=0 -> 0xFFFFFFFF. REMU -> 100. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM -> 0.
  - Latency is 33 cycles without MULDIV_EARLY_EN and 2 cycles with it.
- start pulses while busy, with different operands and rd_in -> ignored; the original op completes with its captured rd_out.
- rst_n low at cycle 10 of a DIV -> busy, done, result and rd_out are 0 immediately. After release, no done appears until a new start.
